// File: rtl/wrr_read_sched_if.sv
//----------------------------------------------------------------------------
// wrr_read_sched_if
// Bundle of the signals between the egress priority queues, the weighted
// round-robin read scheduler and one packet-reader channel.
//
//   Queue side : iQueAddr0..3, iQueBlockNum0..3, iQueDrop0..3, iQueVld0..3
//                (head-of-queue descriptors), oQueRdy0..3 (pop strobes),
//                iWeight0..3 (per-queue weights, 0 disables a queue)
//   Reader side: oPkgFirAddr, oPkgBlockNum, oPkgDrop, oPkgFirAddrVld
//                (issued request), iPkgFirAddrRdy (request accepted),
//                iPkgDone (non-drop packet finished)
//
// Modports: slave = the scheduler, master = whatever drives the scheduler.
//----------------------------------------------------------------------------
interface wrr_read_sched_if #(
   parameter int ADDR_LENTH   = 12,
   parameter int WEIGHT_WIDTH = 4
);
   logic [ADDR_LENTH-1:0]   iQueAddr0, iQueAddr1, iQueAddr2, iQueAddr3;
   logic [3:0]              iQueBlockNum0, iQueBlockNum1, iQueBlockNum2, iQueBlockNum3;
   logic                    iQueDrop0, iQueDrop1, iQueDrop2, iQueDrop3;
   logic                    iQueVld0, iQueVld1, iQueVld2, iQueVld3;
   logic                    oQueRdy0, oQueRdy1, oQueRdy2, oQueRdy3;
   logic [WEIGHT_WIDTH-1:0] iWeight0, iWeight1, iWeight2, iWeight3;
   logic [ADDR_LENTH-1:0]   oPkgFirAddr;
   logic [3:0]              oPkgBlockNum;
   logic                    oPkgDrop;
   logic                    oPkgFirAddrVld;
   logic                    iPkgFirAddrRdy;
   logic                    iPkgDone;

   modport slave (
      input  iQueAddr0, iQueAddr1, iQueAddr2, iQueAddr3,
      input  iQueBlockNum0, iQueBlockNum1, iQueBlockNum2, iQueBlockNum3,
      input  iQueDrop0, iQueDrop1, iQueDrop2, iQueDrop3,
      input  iQueVld0, iQueVld1, iQueVld2, iQueVld3,
      output oQueRdy0, oQueRdy1, oQueRdy2, oQueRdy3,
      input  iWeight0, iWeight1, iWeight2, iWeight3,
      output oPkgFirAddr, oPkgBlockNum, oPkgDrop, oPkgFirAddrVld,
      input  iPkgFirAddrRdy, iPkgDone
   );

   modport master (
      output iQueAddr0, iQueAddr1, iQueAddr2, iQueAddr3,
      output iQueBlockNum0, iQueBlockNum1, iQueBlockNum2, iQueBlockNum3,
      output iQueDrop0, iQueDrop1, iQueDrop2, iQueDrop3,
      output iQueVld0, iQueVld1, iQueVld2, iQueVld3,
      input  oQueRdy0, oQueRdy1, oQueRdy2, oQueRdy3,
      output iWeight0, iWeight1, iWeight2, iWeight3,
      input  oPkgFirAddr, oPkgBlockNum, oPkgDrop, oPkgFirAddrVld,
      output iPkgFirAddrRdy, iPkgDone
   );
endinterface

// File: rtl/wrr_read_sched.sv
//----------------------------------------------------------------------------
// wrr_read_sched
// Weighted round-robin scheduler for one egress read channel. Picks one of
// four priority queues, pops its head descriptor, presents it to the packet
// reader and waits for that packet to finish before picking again.
//
// Ports
//   iClk, iRst   : clock (rising edge), synchronous active-high reset
//   bus          : wrr_read_sched_if.slave (queue heads, pop strobes,
//                  weights, packet request and completion)
//   oDbgState    : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT)
//   oDbgGntIdx   : index of the most recently granted queue
//
// Handshake: a request is transferred in a cycle where oPkgFirAddrVld and
// iPkgFirAddrRdy are both 1. Once raised, oPkgFirAddrVld and the request
// fields stay constant until that transfer; oPkgFirAddrVld falls on the
// following cycle. oQueRdyN is a one-cycle pop with no back-pressure: the
// queue must advance its head after any cycle in which it is seen high.
//----------------------------------------------------------------------------
module wrr_read_sched #(
   parameter int ADDR_LENTH   = 12,
   parameter int WEIGHT_WIDTH = 4
) (
   input  logic             iClk,
   input  logic             iRst,
   wrr_read_sched_if.slave  bus,
   output logic [1:0]       oDbgState,
   output logic [1:0]       oDbgGntIdx
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   state_e                  state_q;
   logic [WEIGHT_WIDTH-1:0] credit_q [4];
   logic [1:0]              ptr_q;
   logic [1:0]              gnt_idx_q;
   logic [ADDR_LENTH-1:0]   pkg_addr_q;
   logic [3:0]              pkg_bn_q;
   logic                    pkg_drop_q;
   logic                    pkg_vld_q;

   // Queue inputs gathered into arrays so they can be indexed by queue number.
   logic [ADDR_LENTH-1:0]   que_addr [4];
   logic [3:0]              que_bn   [4];
   logic [WEIGHT_WIDTH-1:0] weight   [4];
   logic [3:0]              que_drop;
   logic [3:0]              que_vld;

   always_comb begin
      que_addr[0] = bus.iQueAddr0;
      que_addr[1] = bus.iQueAddr1;
      que_addr[2] = bus.iQueAddr2;
      que_addr[3] = bus.iQueAddr3;
      que_bn[0]   = bus.iQueBlockNum0;
      que_bn[1]   = bus.iQueBlockNum1;
      que_bn[2]   = bus.iQueBlockNum2;
      que_bn[3]   = bus.iQueBlockNum3;
      weight[0]   = bus.iWeight0;
      weight[1]   = bus.iWeight1;
      weight[2]   = bus.iWeight2;
      weight[3]   = bus.iWeight3;
      que_drop    = {bus.iQueDrop3, bus.iQueDrop2, bus.iQueDrop1, bus.iQueDrop0};
      que_vld     = {bus.iQueVld3, bus.iQueVld2, bus.iQueVld1, bus.iQueVld0};
   end

   // Selection: first eligible queue scanning from ptr upwards (mod 4).
   logic [3:0]              elig;
   logic [3:0]              wt_nz;
   logic                    any_elig;
   logic                    found;
   logic [1:0]              scan_idx;
   logic [1:0]              sel_idx_d;
   logic [WEIGHT_WIDTH-1:0] credit_dec_d;
   logic                    reload_req;
   logic                    grant;
   logic [3:0]              que_rdy;

   always_comb begin
      elig      = '0;
      wt_nz     = '0;
      found     = 1'b0;
      scan_idx  = ptr_q;
      sel_idx_d = ptr_q;
      for (int q = 0; q < 4; q++) begin
         elig[q]  = que_vld[q] && (credit_q[q] != '0);
         wt_nz[q] = (weight[q] != '0);
      end
      any_elig = |elig;
      for (int i = 0; i < 4; i++) begin
         scan_idx = ptr_q + 2'(i);
         if (!found && elig[scan_idx]) begin
            sel_idx_d = scan_idx;
            found     = 1'b1;
         end
      end
      credit_dec_d = credit_q[sel_idx_d] - WEIGHT_WIDTH'(1);
      // A new round starts only when nothing is eligible yet some valid queue
      // would receive non-zero credit; otherwise a reload would spin forever.
      reload_req   = !any_elig && ((que_vld & wt_nz) != 4'b0000);
      // The pop strobe is gated by reset so a queue is never popped while the
      // grant it belongs to is being abandoned.
      grant        = (state_q == ST_IDLE) && any_elig && !iRst;
      que_rdy      = grant ? (4'(1) << sel_idx_d) : 4'b0000;
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q    <= ST_IDLE;
         for (int q = 0; q < 4; q++) credit_q[q] <= '0;
         ptr_q      <= 2'd0;
         gnt_idx_q  <= 2'd0;
         pkg_addr_q <= '0;
         pkg_bn_q   <= 4'd0;
         pkg_drop_q <= 1'b0;
         pkg_vld_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_elig) begin
                  credit_q[sel_idx_d] <= credit_dec_d;
                  // Stay on a queue while it has credit so its weight is
                  // served as a burst; move past it once exhausted.
                  ptr_q      <= (credit_dec_d != '0) ? sel_idx_d : sel_idx_d + 2'd1;
                  gnt_idx_q  <= sel_idx_d;
                  pkg_addr_q <= que_addr[sel_idx_d];
                  pkg_bn_q   <= que_bn[sel_idx_d];
                  pkg_drop_q <= que_drop[sel_idx_d];
                  pkg_vld_q  <= 1'b1;
                  state_q    <= ST_ISSUE;
               end else if (reload_req) begin
                  for (int q = 0; q < 4; q++) credit_q[q] <= weight[q];
               end
            end
            ST_ISSUE: begin
               if (bus.iPkgFirAddrRdy) begin
                  pkg_vld_q <= 1'b0;
                  // Drop packets produce no data beats, so no completion comes.
                  state_q   <= pkg_drop_q ? ST_IDLE : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.iPkgDone) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.oQueRdy0       = que_rdy[0];
   assign bus.oQueRdy1       = que_rdy[1];
   assign bus.oQueRdy2       = que_rdy[2];
   assign bus.oQueRdy3       = que_rdy[3];
   assign bus.oPkgFirAddr    = pkg_addr_q;
   assign bus.oPkgBlockNum   = pkg_bn_q;
   assign bus.oPkgDrop       = pkg_drop_q;
   assign bus.oPkgFirAddrVld = pkg_vld_q;
   assign oDbgState          = state_q;
   assign oDbgGntIdx         = gnt_idx_q;

endmodule

// File: tb/tb_wrr_read_sched.sv
//----------------------------------------------------------------------------
// tb_wrr_read_sched
// Testbench for wrr_read_sched. Queue sources and the packet reader are
// modelled behaviourally; expected requests {queue, addr, blocks, drop} are
// queued as each scenario is set up and compared while the DUT presents them.
//----------------------------------------------------------------------------
module tb_wrr_read_sched;

   localparam int AW = 12;
   localparam int WW = 4;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wrr_read_sched_if #(.ADDR_LENTH(AW), .WEIGHT_WIDTH(WW)) bus ();
   logic [1:0] dbg_state;
   logic [1:0] dbg_gnt;

   wrr_read_sched #(.ADDR_LENTH(AW), .WEIGHT_WIDTH(WW)) dut (
      .iClk       (clk),
      .iRst       (rst),
      .bus        (bus),
      .oDbgState  (dbg_state),
      .oDbgGntIdx (dbg_gnt)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- bench state ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [18:0] exp_q[$];          // {queue, addr, blocks, drop}
   bit          sb_en;

   int              src_left [4];  // descriptors left, -1 = endless
   logic [AW-1:0]   src_addr [4];
   logic [3:0]      src_bn   [4];
   logic            src_drop [4];
   logic [WW-1:0]   wt       [4];
   logic [AW-1:0]   exp_addr [4];
   logic [3:0]      exp_bn   [4];
   int              gcount   [4];

   int rdy_block, done_delay, done_cnt, cyc, last_done_cyc;
   bit force_done, drv_rdy, drv_done;

   logic [3:0]    obs_rdy;
   logic          obs_vld, obs_drop, obs_hs;
   logic [AW-1:0] obs_addr;
   logic [3:0]    obs_bn;
   logic [1:0]    obs_state;
   bit            prev_gnt, prev_hs;

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic push_exp(input int q);
      exp_q.push_back({2'(q), exp_addr[q], exp_bn[q], src_drop[q]});
      exp_addr[q]++;
      exp_bn[q]++;
   endtask

   task automatic arm();
      for (int q = 0; q < 4; q++) begin
         exp_addr[q] = src_addr[q];
         exp_bn[q]   = src_bn[q];
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive_inputs();
      bus.iQueAddr0     = src_addr[0];
      bus.iQueAddr1     = src_addr[1];
      bus.iQueAddr2     = src_addr[2];
      bus.iQueAddr3     = src_addr[3];
      bus.iQueBlockNum0 = src_bn[0];
      bus.iQueBlockNum1 = src_bn[1];
      bus.iQueBlockNum2 = src_bn[2];
      bus.iQueBlockNum3 = src_bn[3];
      bus.iQueDrop0     = src_drop[0];
      bus.iQueDrop1     = src_drop[1];
      bus.iQueDrop2     = src_drop[2];
      bus.iQueDrop3     = src_drop[3];
      bus.iQueVld0      = (src_left[0] != 0);
      bus.iQueVld1      = (src_left[1] != 0);
      bus.iQueVld2      = (src_left[2] != 0);
      bus.iQueVld3      = (src_left[3] != 0);
      bus.iWeight0      = wt[0];
      bus.iWeight1      = wt[1];
      bus.iWeight2      = wt[2];
      bus.iWeight3      = wt[3];
      bus.iPkgFirAddrRdy = drv_rdy;
      bus.iPkgDone       = drv_done;
   endtask

   // Observe the current cycle and run the per-cycle checks/scoreboard.
   task automatic sample();
      prev_gnt  = (obs_rdy != 4'b0000);
      prev_hs   = obs_hs;
      obs_rdy   = {bus.oQueRdy3, bus.oQueRdy2, bus.oQueRdy1, bus.oQueRdy0};
      obs_vld   = bus.oPkgFirAddrVld;
      obs_addr  = bus.oPkgFirAddr;
      obs_bn    = bus.oPkgBlockNum;
      obs_drop  = bus.oPkgDrop;
      obs_state = dbg_state;
      obs_hs    = obs_vld && drv_rdy && !rst;
      if (rst) begin
         // The edge just taken had reset high: everything must be at reset.
         chk("rst_vld",   32'(obs_vld),   32'd0);
         chk("rst_addr",  32'(obs_addr),  32'd0);
         chk("rst_bn",    32'(obs_bn),    32'd0);
         chk("rst_drop",  32'(obs_drop),  32'd0);
         chk("rst_rdy",   32'(obs_rdy),   32'd0);
         chk("rst_state", 32'(obs_state), 32'(S_IDLE));
         prev_gnt = 1'b0;
         obs_hs   = 1'b0;
      end else begin
         chk("rdy_onehot0", 32'($onehot0(obs_rdy)), 32'd1);
         if (obs_rdy != 4'b0000) begin
            chk("rdy_in_idle", 32'(obs_state), 32'(S_IDLE));
            for (int q = 0; q < 4; q++) if (obs_rdy[q]) gcount[q]++;
         end
         if (prev_gnt) chk("vld_after_grant", 32'(obs_vld), 32'd1);
         if (prev_hs)  chk("vld_low_after_hs", 32'(obs_vld), 32'd0);
         if (obs_vld) begin
            chk("state_issue", 32'(obs_state), 32'(S_ISSUE));
            if (sb_en) begin
               if (exp_q.size() == 0) chk("unexpected_req", 32'(exp_q.size()), 32'd1);
               else begin
                  chk("req", 32'({dbg_gnt, obs_addr, obs_bn, obs_drop}), 32'(exp_q[0]));
                  if (obs_hs) void'(exp_q.pop_front());
               end
            end
         end
      end
   endtask

   // One clock: DUT edge, then queue/reader models react, then observe.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      for (int q = 0; q < 4; q++) begin
         if (obs_rdy[q]) begin
            if (src_left[q] > 0) src_left[q]--;
            src_addr[q]++;
            src_bn[q]++;
         end
      end
      drv_done = 1'b0;
      if (rst) done_cnt = 0;
      else begin
         if (obs_hs && !obs_drop) done_cnt = done_delay;
         if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) drv_done = 1'b1;
         end
         if (force_done && bus.oPkgFirAddrVld) drv_done = 1'b1;
      end
      if (drv_done) last_done_cyc = cyc;
      if (bus.oPkgFirAddrVld && rdy_block > 0) begin
         drv_rdy = 1'b0;
         rdy_block--;
      end else drv_rdy = 1'b1;
      drive_inputs();
      #1;
      sample();
   endtask

   task automatic start_test(input logic [WW-1:0] w0, w1, w2, w3);
      wt[0] = w0; wt[1] = w1; wt[2] = w2; wt[3] = w3;
      for (int q = 0; q < 4; q++) begin
         src_left[q] = 0;
         src_addr[q] = AW'(q * 256);
         src_bn[q]   = 4'(q + 1);
         src_drop[q] = 1'b0;
         gcount[q]   = 0;
      end
      rdy_block  = 0;
      force_done = 1'b0;
      done_delay = 2;
      sb_en      = 1'b1;
      exp_q.delete();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int  n;
      bit  hs_seen, reval;
      obs_rdy = '0; obs_vld = 0; obs_drop = 0; obs_hs = 0; obs_addr = '0;
      obs_bn = '0; obs_state = '0; prev_gnt = 0; prev_hs = 0;
      cyc = 0; last_done_cyc = 0; done_cnt = 0;
      drv_rdy = 1'b1; drv_done = 1'b0;
      for (int q = 0; q < 4; q++) begin
         src_left[q] = 0; src_addr[q] = '0; src_bn[q] = '0; src_drop[q] = 0; wt[q] = '0;
      end
      drive_inputs();

      // 1: lone valid queue. With weight 0 it is never served; once its
      //    weight is non-zero: reload cycle, pop cycle, then the request.
      start_test(4'd3, 4'd1, 4'd0, 4'd2);
      src_left[2] = 1; src_addr[2] = 12'h123; src_bn[2] = 4'd5;
      arm();
      push_exp(2);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t1_w0_no_rdy", 32'(obs_rdy), 32'd0);
      end
      wt[2] = 4'd1;
      step();
      chk("t1_reload_no_rdy", 32'(obs_rdy), 32'd0);
      step();
      chk("t1_rdy2", 32'(obs_rdy), 32'b0100);
      step();
      chk("t1_vld", 32'(obs_vld), 32'd1);
      chk("t1_addr", 32'(obs_addr), 32'h123);
      chk("t1_bn", 32'(obs_bn), 32'd5);
      drain("t1_drain", 50);

      // 2: all queues always valid, weights 3,1,0,2: two full rounds.
      start_test(4'd3, 4'd1, 4'd0, 4'd2);
      for (int q = 0; q < 4; q++) src_left[q] = -1;
      arm();
      for (int r = 0; r < 2; r++) begin
         push_exp(0); push_exp(0); push_exp(0); push_exp(1); push_exp(3); push_exp(3);
      end
      drain("t2_drain", 300);
      chk("t2_q2_never", 32'(gcount[2]), 32'd0);
      chk("t2_q0_count", 32'(gcount[0]), 32'd6);

      // 3: reader back-pressure for five cycles in ISSUE.
      start_test(4'd1, 4'd0, 4'd0, 4'd0);
      src_left[0] = 1; src_addr[0] = 12'hABC; src_bn[0] = 4'd7;
      arm();
      push_exp(0);
      rdy_block = 5;
      step();
      chk("t3_reload_no_rdy", 32'(obs_rdy), 32'd0);
      step();
      chk("t3_rdy0", 32'(obs_rdy), 32'b0001);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_stall_vld", 32'(obs_vld), 32'd1);
         chk("t3_stall_addr", 32'(obs_addr), 32'hABC);
         chk("t3_stall_bn", 32'(obs_bn), 32'd7);
         chk("t3_stall_no_rdy", 32'(obs_rdy), 32'd0);
      end
      step();
      chk("t3_hs_cycle_vld", 32'(obs_vld), 32'd1);
      step();
      chk("t3_wait", 32'(obs_state), 32'(S_WAIT));
      drain("t3_drain", 20);

      // 4: drop descriptors from queue 1; completion pulses during ISSUE.
      start_test(4'd0, 4'd2, 4'd0, 4'd0);
      src_left[1] = 2; src_drop[1] = 1'b1; src_addr[1] = 12'h456;
      arm();
      push_exp(1); push_exp(1);
      rdy_block  = 3;
      force_done = 1'b1;
      step();
      step();
      chk("t4_rdy1", 32'(obs_rdy), 32'b0010);
      hs_seen = 0; n = 0;
      while (!hs_seen && n < 20) begin
         step();
         n++;
         if (obs_hs) hs_seen = 1;
      end
      chk("t4_hs_seen", 32'(hs_seen), 32'd1);
      step();
      chk("t4_regrant_h1", 32'(obs_rdy), 32'b0010);
      chk("t4_idle_h1", 32'(obs_state), 32'(S_IDLE));
      drain("t4_drain", 20);
      step();
      chk("t4_idle_after", 32'(obs_state), 32'(S_IDLE));
      chk("t4_no_rdy_after", 32'(obs_rdy), 32'd0);

      // 5: weights 2,2,2,2; queue 0 empties after one grant and returns
      //    before the round ends, then uses its remaining credit.
      start_test(4'd2, 4'd2, 4'd2, 4'd2);
      src_left[0] = 1; src_left[1] = -1; src_left[2] = -1; src_left[3] = -1;
      arm();
      push_exp(0); push_exp(1); push_exp(1); push_exp(2);
      push_exp(2); push_exp(3); push_exp(3); push_exp(0);
      reval = 0; n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         if (exp_q.size() == 1 && !reval) begin
            src_left[0] = 1;
            reval = 1;
         end
         step();
         n++;
         if (reval && obs_rdy[0]) chk("t5_gnt_gap", 32'(cyc - last_done_cyc), 32'd1);
      end
      chk("t5_drain", 32'(exp_q.size()), 32'd0);
      chk("t5_q0_count", 32'(gcount[0]), 32'd2);

      // 6: reset in WAIT and in ISSUE.
      start_test(4'd1, 4'd1, 4'd1, 4'd1);
      for (int q = 0; q < 4; q++) src_left[q] = -1;
      arm();
      sb_en = 1'b0;
      done_delay = 0;
      step();
      chk("t6_reload", 32'(obs_rdy), 32'd0);
      step();
      chk("t6_rdy0", 32'(obs_rdy), 32'b0001);
      step();
      chk("t6_issue_vld", 32'(obs_vld), 32'd1);
      step();
      chk("t6_wait", 32'(obs_state), 32'(S_WAIT));
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("t6_w_reload_no_rdy", 32'({bus.oQueRdy3, bus.oQueRdy2, bus.oQueRdy1, bus.oQueRdy0}), 32'd0);
      step();
      chk("t6_w_regrant0", 32'(obs_rdy), 32'b0001);
      rdy_block = 3;
      step();
      chk("t6_issue", 32'(obs_state), 32'(S_ISSUE));
      rst = 1'b1;
      step();
      rst = 1'b0;
      rdy_block = 0;
      #1;
      chk("t6_i_reload_no_rdy", 32'({bus.oQueRdy3, bus.oQueRdy2, bus.oQueRdy1, bus.oQueRdy0}), 32'd0);
      step();
      chk("t6_i_regrant0", 32'(obs_rdy), 32'b0001);
      chk("t6_i_vld_low", 32'(obs_vld), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
